// File: rtl/canvas_pkg.sv
// canvas_pkg: shared types, constants and the raster-step helper for the
// canvas reader slice (reader top, address counter, stream interface).
package canvas_pkg;

    localparam int CANVAS_DIM = 28;

    typedef logic [15:0] pixel_t;
    typedef logic [4:0]  coord_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } reader_state_t;

    typedef struct packed {
        coord_t row;
        coord_t col;
    } addr_t;

    // Raster successor of an address: column first, wrapping into the next row;
    // the final pixel wraps back to the origin.
    function automatic addr_t next_addr(addr_t cur, coord_t max_idx);
        addr_t nxt;
        nxt = cur;
        if (cur.col == max_idx) begin
            nxt.col = '0;
            nxt.row = (cur.row == max_idx) ? '0 : cur.row + 5'd1;
        end else begin
            nxt.col = cur.col + 5'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/canvas_reader_if.sv
// canvas_reader_if: valid/ready pixel stream carrying one pixel value with its
// raster coordinates and an end-of-frame marker.
interface canvas_reader_if;
    import canvas_pkg::*;

    logic   pix_valid;
    logic   pix_ready;
    pixel_t pix_data;
    coord_t pix_row;
    coord_t pix_col;
    logic   pix_last;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_row,
        output pix_col,
        output pix_last,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_row,
        input  pix_col,
        input  pix_last,
        output pix_ready
    );

endinterface

// File: rtl/canvas_addr_ctr.sv
// canvas_addr_ctr: raster address register for the pixel currently presented.
// clr returns to the origin and wins over inc; last flags the final pixel.
module canvas_addr_ctr
    import canvas_pkg::*;
#(
    parameter int DIM = CANVAS_DIM
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   inc,
    input  logic   clr,
    output coord_t row,
    output coord_t col,
    output logic   last
);

    localparam coord_t MAX_IDX = coord_t'(DIM - 1);

    addr_t nxt;

    assign nxt  = next_addr(addr_t'({row, col}), MAX_IDX);
    assign last = (row == MAX_IDX) && (col == MAX_IDX);

    // Hold, clear to the origin, or step to the raster successor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (inc) begin
            row <= nxt.row;
            col <= nxt.col;
        end
    end

endmodule

// File: rtl/canvas_reader.sv
// canvas_reader: streams a DIM x DIM canvas out in raster order over a
// valid/ready pixel interface, reading each pixel live at its load cycle.
// Optional build macro CANVAS_READER_THRESH_EN binarizes pixels against THRESH.
module canvas_reader
    import canvas_pkg::*;
#(
    parameter int     DIM    = CANVAS_DIM,
    parameter pixel_t THRESH = 16'h8000
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   abort,
    input  pixel_t canvas [DIM-1:0][DIM-1:0],
    canvas_reader_if.master pix,
    output logic   busy,
    output logic   done
);

    reader_state_t state;
    logic          valid;
    pixel_t        data;
    logic          handshake;
    logic          ctr_inc;
    logic          ctr_clr;
    logic          at_last;
    coord_t        row;
    coord_t        col;
    addr_t         nxt;

`ifdef CANVAS_READER_THRESH_EN
    function automatic pixel_t shape_pixel(pixel_t raw);
        return (raw >= THRESH) ? 16'hFFFF : 16'h0000;
    endfunction
`else
    function automatic pixel_t shape_pixel(pixel_t raw);
        return raw;
    endfunction

    // THRESH has no role in the raw build; fold it into a dummy net.
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
`endif

    assign handshake = (state == STREAM) && valid && pix.pix_ready;
    assign ctr_clr   = ((state == IDLE) && start)
                     || ((state == STREAM) && abort)
                     || (handshake && at_last);
    assign ctr_inc   = handshake && !abort && !at_last;
    assign nxt       = next_addr(addr_t'({row, col}), coord_t'(DIM - 1));

    canvas_addr_ctr #(
        .DIM (DIM)
    ) u_addr_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctr_inc),
        .clr   (ctr_clr),
        .row   (row),
        .col   (col),
        .last  (at_last)
    );

    assign pix.pix_valid = valid;
    assign pix.pix_data  = data;
    assign pix.pix_row   = row;
    assign pix.pix_col   = col;
    assign pix.pix_last  = at_last && valid;

    // Frame sequencer: launch on start, load the next pixel on each handshake,
    // finish through a one-cycle DONE, and drop the frame on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            valid <= 1'b0;
            data  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= STREAM;
                        valid <= 1'b1;
                        busy  <= 1'b1;
                        data  <= shape_pixel(canvas[0][0]);
                    end
                end
                STREAM: begin
                    if (abort) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end else if (handshake) begin
                        if (at_last) begin
                            state <= DONE;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            data <= shape_pixel(canvas[nxt.row][nxt.col]);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_canvas_reader.sv
// tb_canvas_reader: scoreboard bench for canvas_reader. Expected pixels are
// queued when a frame is launched and popped on each observed handshake.
module tb_canvas_reader;
    import canvas_pkg::*;

    localparam int     DIM    = 28;
    localparam pixel_t THRESH = 16'h8000;

    typedef struct packed {
        pixel_t data;
        coord_t row;
        coord_t col;
        logic   last;
    } exp_t;

    logic   clk;
    logic   rst_n;
    logic   start;
    logic   abort;
    logic   busy;
    logic   done;
    pixel_t canvas [DIM-1:0][DIM-1:0];

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    canvas_reader_if pix();

    canvas_reader #(
        .DIM    (DIM),
        .THRESH (THRESH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .canvas (canvas),
        .pix    (pix.master),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic pixel_t model_pix(pixel_t raw);
`ifdef CANVAS_READER_THRESH_EN
        return (raw >= THRESH) ? 16'hFFFF : 16'h0000;
`else
        return raw;
`endif
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.data = pix.pix_data;
        o.row  = pix.pix_row;
        o.col  = pix.pix_col;
        o.last = pix.pix_last;
        return o;
    endfunction

    task automatic fill_ramp();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                canvas[r][c] = pixel_t'(r * DIM + c);
    endtask

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                e.data = model_pix(canvas[r][c]);
                e.row  = coord_t'(r);
                e.col  = coord_t'(c);
                e.last = (r == DIM - 1) && (c == DIM - 1);
                sb.push_back(e);
            end
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        $display("[TB] reset state and idle abort");
        #3;
        vectors++;
        if ({pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col, pix.pix_last, busy, done} !== 30'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got v=%b d=%h r=%0d c=%0d l=%b busy=%b done=%b, want all 0",
                     pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col, pix.pix_last, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        vectors++;
        if ({pix.pix_valid, busy, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL idle_abort: got v/busy/done=%b, want 000", {pix.pix_valid, busy, done});
        end
    endtask

    task automatic test_stream_full();
        int   hs;
        bit   last_seen;
        exp_t e;
        exp_t o;
        $display("[TB] full frame with ready held high");
        hs = 0;
        last_seen = 0;
        pix.pix_ready = 1'b1;
        push_frame();
        do_start();
        for (int cyc = 0; cyc < 2 * DIM * DIM && !last_seen; cyc++) begin
            @(negedge clk);
            vectors++;
            if (pix.pix_valid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL full_bubble: got valid=%b at cycle %0d, want 1", pix.pix_valid, cyc);
            end else if (sb.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL full_extra: got extra pixel (%0d,%0d), want none", pix.pix_row, pix.pix_col);
            end else begin
                e = sb.pop_front();
                o = observed();
                hs++;
                last_seen = e.last;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL full_pixel: got %h (%0d,%0d) last=%b, want %h (%0d,%0d) last=%b",
                             o.data, o.row, o.col, o.last, e.data, e.row, e.col, e.last);
                end
            end
            @(posedge clk);
            #1;
        end
        vectors++;
        if (hs != DIM * DIM || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL full_count: got %0d handshakes, want %0d", hs, DIM * DIM);
        end
        @(negedge clk);
        vectors++;
        if ({done, pix.pix_valid, busy} !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL full_done: got done/valid/busy=%b, want 101", {done, pix.pix_valid, busy});
        end
        @(negedge clk);
        vectors++;
        if ({done, pix.pix_valid, busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL full_after_done: got done/valid/busy=%b, want 000", {done, pix.pix_valid, busy});
        end
        sb.delete();
    endtask

    task automatic test_backpressure();
        int     hs;
        bit     last_seen;
        bit     held_valid;
        pixel_t held_data;
        coord_t held_row;
        coord_t held_col;
        exp_t   e;
        exp_t   o;
        $display("[TB] full frame with random ready");
        hs = 0;
        last_seen = 0;
        held_valid = 0;
        held_data = '0;
        held_row = '0;
        held_col = '0;
        pix.pix_ready = 1'($urandom_range(0, 1));
        push_frame();
        do_start();
        for (int cyc = 0; cyc < 8 * DIM * DIM && !last_seen; cyc++) begin
            @(negedge clk);
            if (held_valid) begin
                vectors++;
                if ({pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col} !== {1'b1, held_data, held_row, held_col}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold: got v=%b %h (%0d,%0d), want v=1 %h (%0d,%0d)",
                             pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col, held_data, held_row, held_col);
                end
            end
            if (pix.pix_valid && pix.pix_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_extra: got extra pixel (%0d,%0d), want none", pix.pix_row, pix.pix_col);
                end else begin
                    e = sb.pop_front();
                    o = observed();
                    hs++;
                    last_seen = e.last;
                    if (o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL bp_pixel: got %h (%0d,%0d) last=%b, want %h (%0d,%0d) last=%b",
                                 o.data, o.row, o.col, o.last, e.data, e.row, e.col, e.last);
                    end
                end
            end
            held_valid = pix.pix_valid && !pix.pix_ready;
            held_data  = pix.pix_data;
            held_row   = pix.pix_row;
            held_col   = pix.pix_col;
            @(posedge clk);
            #1 pix.pix_ready = 1'($urandom_range(0, 1));
        end
        vectors++;
        if (hs != DIM * DIM || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL bp_count: got %0d handshakes, want %0d", hs, DIM * DIM);
        end
        @(negedge clk);
        vectors++;
        if ({done, pix.pix_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL bp_done: got done/valid=%b, want 10", {done, pix.pix_valid});
        end
        pix.pix_ready = 1'b1;
        @(negedge clk);
        sb.delete();
    endtask

    task automatic test_abort();
        bit   aborted;
        exp_t e;
        exp_t o;
        $display("[TB] abort at pixel (3,5) then restart");
        aborted = 0;
        pix.pix_ready = 1'b1;
        push_frame();
        do_start();
        for (int cyc = 0; cyc < 2 * DIM * DIM && !aborted; cyc++) begin
            @(negedge clk);
            if (pix.pix_valid && pix.pix_ready && sb.size() != 0) begin
                e = sb.pop_front();
                o = observed();
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL abort_pixel: got %h (%0d,%0d), want %h (%0d,%0d)",
                             o.data, o.row, o.col, e.data, e.row, e.col);
                end
            end
            if (pix.pix_valid && pix.pix_row == 5'd3 && pix.pix_col == 5'd5) begin
                abort = 1'b1;
                aborted = 1;
            end
            @(posedge clk);
            #1 abort = 1'b0;
        end
        vectors++;
        if (!aborted) begin
            miscompares++;
            $display("[TB] FAIL abort_reach: got no pixel (3,5), want it within budget");
        end
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({pix.pix_valid, busy, done} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL abort_idle: got v/busy/done=%b at cycle %0d, want 000", {pix.pix_valid, busy, done}, i);
            end
        end
        push_frame();
        do_start();
        @(negedge clk);
        e = sb.pop_front();
        o = observed();
        vectors++;
        if ({pix.pix_valid, o} !== {1'b1, e}) begin
            miscompares++;
            $display("[TB] FAIL abort_restart: got v=%b %h (%0d,%0d), want v=1 %h (%0d,%0d)",
                     pix.pix_valid, o.data, o.row, o.col, e.data, e.row, e.col);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_midframe();
        bit reached;
        $display("[TB] reset pulse at pixel (10,0)");
        reached = 0;
        pix.pix_ready = 1'b1;
        do_start();
        for (int cyc = 0; cyc < 2 * DIM * DIM && !reached; cyc++) begin
            @(negedge clk);
            if (pix.pix_valid && pix.pix_row == 5'd10 && pix.pix_col == 5'd0)
                reached = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (!reached || {pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col, pix.pix_last, busy, done} !== 30'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: got reached=%b v=%b d=%h r=%0d c=%0d busy=%b, want reached, all 0",
                     reached, pix.pix_valid, pix.pix_data, pix.pix_row, pix.pix_col, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({pix.pix_valid, busy, done} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL reset_stay_idle: got v/busy/done=%b at cycle %0d, want 000", {pix.pix_valid, busy, done}, i);
            end
        end
    endtask

    task automatic test_start_ignored();
        int   hs;
        bit   last_seen;
        exp_t e;
        exp_t o;
        $display("[TB] start pulses during stream and done");
        hs = 0;
        last_seen = 0;
        pix.pix_ready = 1'b1;
        push_frame();
        do_start();
        for (int cyc = 0; cyc < 2 * DIM * DIM && !last_seen; cyc++) begin
            @(negedge clk);
            if (pix.pix_valid && pix.pix_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL si_extra: got extra pixel (%0d,%0d), want none", pix.pix_row, pix.pix_col);
                end else begin
                    e = sb.pop_front();
                    o = observed();
                    hs++;
                    last_seen = e.last;
                    if (o !== e) begin
                        miscompares++;
                        $display("[TB] FAIL si_pixel: got %h (%0d,%0d), want %h (%0d,%0d)",
                                 o.data, o.row, o.col, e.data, e.row, e.col);
                    end
                end
            end
            if (pix.pix_valid && pix.pix_row == 5'd2 && pix.pix_col == 5'd2)
                start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if ({done, busy} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL si_done: got done/busy=%b, want 11", {done, busy});
        end
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if ({pix.pix_valid, busy, done} !== 3'b000) begin
                miscompares++;
                $display("[TB] FAIL si_no_restart: got v/busy/done=%b at cycle %0d, want 000", {pix.pix_valid, busy, done}, i);
            end
        end
        vectors++;
        if (hs != DIM * DIM || sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL si_count: got %0d handshakes, want %0d", hs, DIM * DIM);
        end
        sb.delete();
    endtask

    task automatic test_thresh();
        int   hs;
        exp_t e;
        exp_t o;
        $display("[TB] threshold boundary pixels");
        canvas[0][0] = 16'h7FFF;
        canvas[0][1] = 16'h8000;
        canvas[0][2] = 16'h0000;
        canvas[0][3] = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            e.data = model_pix(canvas[0][c]);
            e.row  = 5'd0;
            e.col  = coord_t'(c);
            e.last = 1'b0;
            sb.push_back(e);
        end
        hs = 0;
        pix.pix_ready = 1'b1;
        do_start();
        for (int cyc = 0; cyc < 20 && sb.size() != 0; cyc++) begin
            @(negedge clk);
            if (pix.pix_valid && pix.pix_ready) begin
                e = sb.pop_front();
                o = observed();
                hs++;
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("[TB] FAIL thresh_pixel: got %h (%0d,%0d), want %h (%0d,%0d)",
                             o.data, o.row, o.col, e.data, e.row, e.col);
                end
                if (sb.size() == 0)
                    abort = 1'b1;
            end
            @(posedge clk);
            #1 abort = 1'b0;
        end
        vectors++;
        if (hs != 4) begin
            miscompares++;
            $display("[TB] FAIL thresh_count: got %0d pixels, want 4", hs);
        end
        sb.delete();
        fill_ramp();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        start         = 1'b0;
        abort         = 1'b0;
        pix.pix_ready = 1'b0;
        fill_ramp();
        test_reset();
        test_stream_full();
        test_backpressure();
        test_abort();
        test_reset_midframe();
        test_start_ignored();
        test_thresh();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/canvas_reader.md
CANVAS_READER -- requirements
Module: canvas_reader

Interface
REQ-001 Parameter DIM, default 28: canvas side length in pixels; rows and columns both span 0..DIM-1.
REQ-002 Parameter THRESH, default 16'h8000: binarization threshold, used only when CANVAS_READER_THRESH_EN is defined.
REQ-003 Clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  request to stream one full canvas frame; sampled only in IDLE.
REQ-006 Abort  input  1  synchronous cancel of a frame in progress.
REQ-007 canvas  input  16 x DIM x DIM (unpacked [DIM-1:0][DIM-1:0])  live canvas array from the canvas editor.
REQ-008 Pix_valid  output  1  Pix_data, Pix_row, Pix_col and Pix_last are valid.
REQ-009 Pix_ready  input  1  downstream accepts the pixel; a handshake is Pix_valid & Pix_ready in the same cycle.
REQ-010 Pix_data  output  16  pixel value.
REQ-011 Pix_row, Pix_col  output  5 each  coordinates of Pix_data.
REQ-012 Pix_last  output  1  high with the pixel at (DIM-1, DIM-1).
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Done  output  1  one-cycle pulse marking frame completion.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, STREAM and DONE.
REQ-016 IDLE with Start=1 SHALL go to STREAM on the next edge, with Pix_valid=1, row/col=(0,0) and Pix_data=canvas[0][0] as sampled at that edge.
REQ-017 Pix_data SHALL be registered and SHALL change only on STREAM entry or on a handshake, so it holds stable while Pix_valid=1 and Pix_ready=0.
REQ-018 On a handshake, col SHALL increment; when col=DIM-1 it SHALL wrap to 0 and row SHALL increment. Pix_data SHALL load canvas at the new coordinates.
REQ-019 A handshake with Pix_last=1 SHALL move to DONE with Pix_valid=0; DONE SHALL assert Done=1 for exactly one cycle and then return to IDLE.
REQ-020 Each frame SHALL produce exactly DIM*DIM handshakes in raster order, with no bubble cycles when Pix_ready stays high.
REQ-021 Start SHALL be ignored in STREAM and DONE; it is neither queued nor restarts the frame.
REQ-022 Abort in STREAM SHALL return the FSM to IDLE on the next edge, with Pix_valid=0 and no Done pulse. Abort SHALL take priority over a same-cycle handshake.
REQ-023 Abort in IDLE or DONE SHALL have no effect.
REQ-024 Canvas changes during a frame SHALL be visible only at each pixel's load cycle; the block takes no snapshot.

Reset
REQ-025 Reset_n=0 SHALL immediately force IDLE and set Pix_valid, Pix_last, Busy and Done to 0, Pix_data to 0, and row/col to 0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL wait for a fresh Start.

Configuration
REQ-027 With CANVAS_READER_THRESH_EN defined, Pix_data SHALL be 16'hFFFF when the canvas pixel is >= THRESH and 16'h0000 otherwise.
REQ-028 With CANVAS_READER_THRESH_EN undefined, Pix_data SHALL be the raw canvas pixel and THRESH SHALL be unused.

Structure
REQ-029 The shared package canvas_pkg SHALL hold CANVAS_DIM=28, pixel_t (16-bit), coord_t (5-bit) and the reader state enum.
REQ-030 The raster address counter SHALL be a sub-module, canvas_addr_ctr, with inputs inc and clr and outputs row, col and last.

Verification
REQ-031 Canvas with pixel = row*28+col, Pix_ready held at 1, Start pulsed: expect 784 consecutive handshakes with values 0..783, Pix_last only on 783, and Done exactly one cycle after the last handshake.
REQ-032 Pix_ready toggled randomly at 50%: while stalled, Pix_data, Pix_row and Pix_col stay unchanged; the sequence and count match the previous scenario.
REQ-033 Abort asserted at the handshake of pixel (3,5): next cycle IDLE, Pix_valid=0, no Done; a new Start restarts the frame at (0,0).
REQ-034 Reset_n pulsed low at pixel (10,0): all outputs go to 0 asynchronously, and the block stays in IDLE after release until Start.
REQ-035 Start pulsed at pixel (2,2) and again during DONE: ignored in both cases, and exactly one frame of 784 handshakes is produced.
REQ-036 With THRESH_EN defined and canvas values 16'h7FFF and 16'h8000: outputs are 16'h0000 and 16'hFFFF respectively. With THRESH_EN undefined, the raw values pass through.
